// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit common-anode 7-segment scan controller with blanking
// and frame-boundary commit of the display word.
module seg_scan_ctrl #(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  en_mask,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {BLANK, ON} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      d_q, d_d;
  logic [15:0]     pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [3:0]      pend_mask_q, pend_mask_d, act_mask_q, act_mask_d;
  logic [3:0]      char_q, char_d, an_q, an_d;
  logic            frame_done_q, frame_done_d, boundary;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    d_d      = d_q;
    boundary = 1'b0;
    if (state_q == BLANK) begin
      if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
        state_d = ON;
        cnt_d   = '0;
      end
    end else if (cnt_q == CW'(ON_CYCLES - 1)) begin
      state_d  = BLANK;
      cnt_d    = '0;
      d_d      = d_q - 2'd1;
      boundary = (d_q == 2'd0);
    end
    pend_val_d   = load ? data_in : pend_val_q;
    pend_mask_d  = load ? en_mask : pend_mask_q;
    act_val_d    = boundary ? pend_val_d : act_val_q;
    act_mask_d   = boundary ? pend_mask_d : act_mask_q;
    // next digit's nibble is latched on BLANK entry, from the freshly committed word at the boundary
    char_d       = (state_q == ON && state_d == BLANK) ? act_val_d[{d_d, 2'b00} +: 4] : char_q;
    an_d         = 4'hF;
    if (state_d == ON) an_d[d_d] = ~act_mask_d[d_d];
    frame_done_d = boundary;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      d_q          <= 2'd3;
      pend_val_q   <= 16'h0000;
      act_val_q    <= 16'h0000;
      pend_mask_q  <= 4'hF;
      act_mask_q   <= 4'hF;
      char_q       <= 4'h0;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      pend_val_q   <= pend_val_d;
      act_val_q    <= act_val_d;
      pend_mask_q  <= pend_mask_d;
      act_mask_q   <= act_mask_d;
      char_q       <= char_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign char       = char_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for a 4-digit, common-anode 7-segment display. It shares one hex-to-segment decoder between the four digits. The block holds a 16-bit display word, presents one 4-bit nibble at a time on `char`, and drives the active-low anode lines in a fixed scan order. Each digit gets a blanking interval before its anode asserts, so the display does not ghost. The block sits between the system logic that produces the display value and the segment decoder and board pins.

## Interface
- `ON_CYCLES`, default 50000: number of clock cycles each digit's anode is asserted; must be ≥ 1.
- `BLANK_CYCLES`, default 500: number of cycles all anodes are off before each digit's ON phase; must be ≥ 1.
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset (asserted when 0, sampled on `clk`).
- `load` input 1: one-cycle strobe that captures `data_in` and `en_mask`.
- `data_in` input 16: display word; `[15:12]` is the leftmost digit (`an[3]`) and `[3:0]` is the rightmost digit (`an[0]`).
- `en_mask` input 4: per-digit enable; 0 keeps that anode dark during its ON phase.
- `char` output 4: nibble for the current digit, fed to the segment decoder.
- `an` output 4: anodes, active-low, at most one bit low at any time.
- `frame_done` output 1: one-cycle pulse at the end of each full 4-digit frame.

## Operation
- **Registers:**
  - `pend_val[15:0]` and `pend_mask[3:0]` form the pending set.
  - `act_val` and `act_mask` form the active set.
  - The scan state is made of `state` ∈ {BLANK, ON}, a 2-bit digit index `d`, and a phase counter sized for max(`ON_CYCLES`, `BLANK_CYCLES`).
- **Load:** `load`=1 copies `data_in` and `en_mask` into the pending set in the same edge. Multiple loads within one frame: the last one wins.
- **Commit:** pending is copied to active only at the frame boundary, which is the last ON cycle of digit 0. This rule prevents tearing inside a frame.
  - If `load` coincides with the boundary cycle, `data_in` and `en_mask` go directly to both the pending and active sets.
- **Scan order:** `d` = 3, 2, 1, 0, then 3 again. `d` wraps from 0 to 3 at the frame boundary.
- **State machine:**
  - In BLANK, `an`=4'b1111 and `char`=`act_val[4d+3:4d]`. After `BLANK_CYCLES` cycles the state goes to ON.
  - In ON, `an[d]`=`~act_mask[d]` and the other anodes are 1. After `ON_CYCLES` cycles the state goes to BLANK and `d` decrements.
- **`char` update:** `char` is registered and changes only on entry to BLANK. It is therefore stable for the whole BLANK+ON window of its digit.
  - Exception: at the frame boundary, `char` for digit 3 is taken from the newly committed value.
- **`frame_done`:** asserted for exactly the cycle after the boundary, i.e. the first BLANK cycle of digit 3.
- **Reset:**
  - Reset has priority over everything, including `load`.
  - Reset mid-scan abandons the current phase; no partial ON phase is extended.
  - Values after reset: `pend_val`=`act_val`=16'h0000, `pend_mask`=`act_mask`=4'b1111, `state`=BLANK, `d`=3, phase counter=0.
  - Outputs after reset: `an`=4'b1111, `char`=4'h0, `frame_done`=0.

## Timing
- Frame length: 4×(`BLANK_CYCLES`+`ON_CYCLES`) cycles; each digit's period is `BLANK_CYCLES`+`ON_CYCLES`.
- After `reset` deasserts, the first `BLANK_CYCLES` cycles are blank. `an[3]` goes low starting at cycle `BLANK_CYCLES`, where cycle 0 is the first cycle with `reset`=1.
- `an` and `char` are both registered outputs, with no combinational path from any input.
- Load-to-display latency: from the next frame boundary, up to 1 frame plus 1 cycle.
- Anode invariant: `an` never has more than one 0. `an` never transitions directly from one digit to another without at least `BLANK_CYCLES` cycles of 4'b1111 in between.

## Test plan
All scenarios use `ON_CYCLES`=4 and `BLANK_CYCLES`=2, giving a 24-cycle frame.
1. **Reset and scan:**
   - Stimulus: hold `reset`=0 for 3 cycles, then release with no load.
   - Required: `an`=1111 for 2 cycles, then 0111 for 4 cycles, 1111 for 2, 1011 for 4, and so on through 1110.
   - Required: `char`=0 throughout; `frame_done` pulses at cycle 24.
2. **Load and commit:**
   - Stimulus: `load` with `data_in`=16'h1A3F and `en_mask`=1111 at cycle 5.
   - Required: `char` stays 0 until the boundary.
   - Required: the next frame shows 1, A, 3, F on digits 3→0, each `char` value valid from the start of its BLANK phase.
3. **Mask:**
   - Stimulus: load 16'hBEEF with `en_mask`=0101.
   - Required: in the following frame, `an` stays 1111 during the ON phases of digits 3 and 1.
   - Required: `an`=1011 and `an`=1110 appear for 4 cycles each.
4. **Load at the boundary:**
   - Stimulus: assert `load` with 16'h4321 on the last ON cycle of digit 0.
   - Required: the immediately following digit-3 BLANK presents `char`=4; no extra frame of delay.
5. **Double load:**
   - Stimulus: load 16'h1111, then 16'h2222 within the same frame.
   - Required: only 2 is displayed in the next frame; 1 never appears.
6. **Reset mid-ON:**
   - Stimulus: assert `reset`=0 on the 2nd ON cycle of digit 1 while `load`=1.
   - Required: on the next edge, `an`=1111, `char`=0, and `act_val`=0.
   - Required: after release, the scan restarts at digit 3 with BLANK.
